api_work_sched: RTL and testbench
=================================

// Module: api_work_sched
// PURPOSE
//  Work dispatcher feeding the API timeout timer (api_timer). Pops 32-bit work words from
//  the CPU-filled TX FIFO and shifts them MSB-first onto the ASIC chain serial bus.
//  After each complete work it pulses spi_load, then timer_start, and holds off the next
//  work until timeout_busy clears. Sits between the TX FIFO and the chain pins/timer.
// PARAMETERS
//  WORD_W   32  shift word width; bit counter is $clog2(WORD_W) bits
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous reset, active-high
//  reg_rst       in   1   synchronous soft reset (same strobe that clears api_timer)
//  reg_run       in   1   dispatch enable
//  reg_word_num  in   8   words per work; 0 is treated as 1
//  reg_sck_div   in   8   sck half-period = reg_sck_div+1 clk cycles
//  fifo_empty    in   1   TX FIFO empty
//  fifo_rdata    in   32  TX FIFO data, valid 1 cycle after fifo_rd
//  fifo_rd       out  1   TX FIFO pop, single-cycle pulse
//  spi_sck       out  1   serial clock to chain, idles low
//  spi_mosi      out  1   serial data, changes while sck is low
//  spi_load      out  1   latch strobe to chain after last word of a work
//  timer_start   out  1   1-cycle pulse to api_timer.start
//  timeout_busy  in   1   api_timer busy
//  busy          out  1   high in any state except IDLE
//  work_done     out  1   1-cycle pulse when the timer wait ends
// BEHAVIOUR
//  - Reset (rst or reg_rst): state IDLE; all outputs 0; shift reg, bit/word/div counters 0.
//    reg_rst acts on the next edge and aborts any state; sck and load drop immediately.
//  - IDLE: if reg_run & !fifo_empty & !timeout_busy -> pulse fifo_rd, go FETCH; word_cnt=0.
//  - FETCH (1 cycle): shreg <= fifo_rdata; bit_cnt = WORD_W-1; mosi <= fifo_rdata[31]; -> SHIFT.
//  - SHIFT: each bit is sck low for div+1 clks, then high for div+1 clks
//    => one word = 64*(div+1) clks. mosi = shreg[31]; shreg shifts left at the end of each high phase.
//    After bit 0's high phase, word_cnt++. If word_cnt == max(reg_word_num,1) -> LOAD.
//    Else, if !fifo_empty -> pulse fifo_rd, go FETCH. Else -> STALL.
//  - STALL: sck low, mosi held; on !fifo_empty pulse fifo_rd -> FETCH.
//  - LOAD: spi_load high for div+1 clks with sck low; then timer_start pulses 1 clk -> WAIT.
//  - WAIT: first cycle ignores timeout_busy (timer latency 1). Then on !timeout_busy,
//    pulse work_done and go IDLE. The next work may start in the cycle after IDLE is entered.
//  - reg_run low mid-work does not abort; the current work completes, then IDLE holds.
//  - reg_sck_div and reg_word_num are sampled live; software changes them only while !busy.
//  - div counter 8-bit, wraps never (reload at div match); word_cnt 8-bit,
//    compared against 9-bit max(reg_word_num,1).
//  - fifo_rd is never asserted while fifo_empty=1 (no underflow possible).
// CONFIGURATION
//  API_MISO_EN defined: adds in spi_miso(1) and out rx_data(32), rx_vld(1). miso is sampled
//    on each sck rising phase and shifted into rx_data LSB. rx_vld pulses 1 clk when a word
//    completes. rx_data and rx_vld reset to 0.
//  Undefined: those ports and the associated logic do not exist.
// TESTING
//  1. div=0, word_num=1, FIFO={A5A5_0001}, run=1
//     -> 32 sck pulses of 2 clks each; mosi pattern 1010...0001; load 1 clk;
//     timer_start 1 clk; work_done once busy drops.
//  2. word_num=3, FIFO holds 2 words, 3rd written 100 clks later -> STALL with sck low;
//     resumes 2 clks after write; exactly 3 fifo_rd; a single load.
//  3. timeout_busy held high externally at IDLE with FIFO non-empty -> no fifo_rd until it
//     drops. Start occurs the cycle after.
//  4. reg_rst asserted mid-SHIFT (bit 12, div=3) -> next cycle IDLE, sck/mosi/busy=0;
//     no load and no timer_start.
//  5. word_num=0, div=2 -> treated as 1 word; each sck phase 3 clks; word=192 clks.
//  6. (API_MISO_EN) miso driven with 0xDEADBEEF MSB-first -> rx_data=DEADBEEF, rx_vld 1 clk
//     at word end.

Source files
------------

// File: rtl/api_work_sched.sv
// Work dispatcher: pops work words from the TX FIFO, shifts them MSB-first to the ASIC chain,
// strobes load, kicks api_timer and waits for it. Optional MISO capture under `API_MISO_EN.
module api_work_sched #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_rst,
    input  logic              reg_run,
    input  logic [7:0]        reg_word_num,
    input  logic [7:0]        reg_sck_div,
    input  logic              fifo_empty,
    input  logic [WORD_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              spi_load,
    output logic              timer_start,
    input  logic              timeout_busy,
    output logic              busy,
    output logic              work_done,
    output logic [2:0]        dbg_state
`ifdef API_MISO_EN
    ,
    input  logic              spi_miso,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_vld
`endif
);

    localparam int BW = $clog2(WORD_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_STALL = 3'd3,
        S_LOAD  = 3'd4,
        S_WAIT  = 3'd5
    } state_t;

    state_t            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [BW-1:0]     bit_q;
    logic [7:0]        word_q;
    logic [7:0]        div_q;
    logic              sck_q;
    logic              load_q;
    logic              timer_start_q;
    logic              work_done_q;
    logic              wait_first_q;
`ifdef API_MISO_EN
    logic [WORD_W-1:0] rx_sh_q;
    logic [WORD_W-1:0] rx_data_q;
    logic              rx_vld_q;
`endif

    logic       div_hit;
    logic       word_end;
    logic [8:0] word_max;
    logic       work_last;

    assign div_hit   = (div_q == reg_sck_div);
    assign word_end  = (state_q == S_SHIFT) && div_hit && sck_q && (bit_q == '0);
    assign word_max  = (reg_word_num == 8'd0) ? 9'd1 : {1'b0, reg_word_num};
    assign work_last = (({1'b0, word_q} + 9'd1) == word_max);

    // Pop is gated by empty and by the soft reset so a word is never lost to an abort.
    assign fifo_rd = !reg_rst && !fifo_empty &&
                     (((state_q == S_IDLE) && reg_run && !timeout_busy) ||
                      (state_q == S_STALL) ||
                      (word_end && !work_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bit_q         <= '0;
            word_q        <= '0;
            div_q         <= '0;
            sck_q         <= 1'b0;
            load_q        <= 1'b0;
            timer_start_q <= 1'b0;
            work_done_q   <= 1'b0;
            wait_first_q  <= 1'b0;
`ifdef API_MISO_EN
            rx_sh_q       <= '0;
            rx_data_q     <= '0;
            rx_vld_q      <= 1'b0;
`endif
        end else if (reg_rst) begin
            state_q       <= S_IDLE;
            shreg_q       <= '0;
            bit_q         <= '0;
            word_q        <= '0;
            div_q         <= '0;
            sck_q         <= 1'b0;
            load_q        <= 1'b0;
            timer_start_q <= 1'b0;
            work_done_q   <= 1'b0;
            wait_first_q  <= 1'b0;
`ifdef API_MISO_EN
            rx_sh_q       <= '0;
            rx_data_q     <= '0;
            rx_vld_q      <= 1'b0;
`endif
        end else begin
            timer_start_q <= 1'b0;
            work_done_q   <= 1'b0;
`ifdef API_MISO_EN
            rx_vld_q      <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (fifo_rd) begin
                        word_q  <= '0;
                        state_q <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    shreg_q <= fifo_rdata;
                    bit_q   <= BW'(WORD_W - 1);
                    div_q   <= '0;
                    sck_q   <= 1'b0;
                    state_q <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!div_hit) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
`ifdef API_MISO_EN
                            rx_sh_q <= {rx_sh_q[WORD_W-2:0], spi_miso};
`endif
                        end else begin
                            sck_q   <= 1'b0;
                            shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
                            if (bit_q != '0) begin
                                bit_q <= bit_q - BW'(1);
                            end else begin
                                word_q <= word_q + 8'd1;
`ifdef API_MISO_EN
                                rx_data_q <= rx_sh_q;
                                rx_vld_q  <= 1'b1;
`endif
                                if (work_last) begin
                                    load_q  <= 1'b1;
                                    state_q <= S_LOAD;
                                end else if (fifo_rd) begin
                                    state_q <= S_FETCH;
                                end else begin
                                    state_q <= S_STALL;
                                end
                            end
                        end
                    end
                end
                S_STALL: begin
                    if (fifo_rd) state_q <= S_FETCH;
                end
                S_LOAD: begin
                    if (!div_hit) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q         <= '0;
                        load_q        <= 1'b0;
                        timer_start_q <= 1'b1;
                        wait_first_q  <= 1'b1;
                        state_q       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The timer raises busy one cycle after start, so the first cycle is blind.
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (!timeout_busy) begin
                        work_done_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spi_sck     = sck_q;
    assign spi_mosi    = shreg_q[WORD_W-1];
    assign spi_load    = load_q;
    assign timer_start = timer_start_q;
    assign work_done   = work_done_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;
`ifdef API_MISO_EN
    assign rx_data     = rx_data_q;
    assign rx_vld      = rx_vld_q;
`endif

endmodule

// File: tb/tb_api_work_sched.sv
// Bench for api_work_sched: FIFO and api_timer models, a bus monitor and scenario tasks.
// Inputs driven 1 time unit after the rising edge; the monitor samples on the falling edge.
module tb_api_work_sched;

    logic        clk = 1'b0;
    logic        rst, reg_rst, reg_run;
    logic [7:0]  wn, div;
    logic        fifo_empty;
    logic [31:0] fifo_rdata;
    logic        fifo_rd, spi_sck, spi_mosi, spi_load, timer_start, busy, work_done;
    logic        timeout_busy;
    logic [2:0]  dbg_state;
    logic        spi_miso;
    logic [31:0] rx_data;
    logic        rx_vld;

    always #5 clk = ~clk;

    api_work_sched #(.WORD_W(32)) dut (
        .clk(clk), .rst(rst), .reg_rst(reg_rst), .reg_run(reg_run),
        .reg_word_num(wn), .reg_sck_div(div),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_load(spi_load),
        .timer_start(timer_start), .timeout_busy(timeout_busy),
        .busy(busy), .work_done(work_done), .dbg_state(dbg_state)
`ifdef API_MISO_EN
        , .spi_miso(spi_miso), .rx_data(rx_data), .rx_vld(rx_vld)
`endif
    );
`ifndef API_MISO_EN
    assign rx_data = 32'h0;
    assign rx_vld  = 1'b0;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    // TX FIFO model: data appears the cycle after a pop.
    logic [31:0] fifo_q[$];
    logic        push_v = 1'b0;
    logic [31:0] push_d = 32'h0;
    initial fifo_empty = 1'b1;
    always @(posedge clk) begin
        if (fifo_rd && fifo_q.size() > 0) fifo_rdata <= fifo_q.pop_front();
        if (push_v) fifo_q.push_back(push_d);
        fifo_empty <= (fifo_q.size() == 0);
    end

    // api_timer model: busy for tdur cycles starting the cycle after start.
    int   tdur = 4;
    int   tcnt = 0;
    logic ext_busy = 1'b0;
    assign timeout_busy = ext_busy || (tcnt != 0);
    always @(posedge clk) begin
        if (timer_start) tcnt <= tdur;
        else if (tcnt > 0) tcnt <= tcnt - 1;
    end

    // Bus monitor
    logic        clr_req = 1'b0;
    logic        bits_q[$];
    logic [31:0] miso_pat = 32'h0;
    int cyc = 0;
    int n_rd, n_underflow, n_load_cyc, n_load_rise, n_ts, n_done, n_sck_in_load, n_rxvld;
    int hi_run, hi_bad, low_run, max_low, first_rise, last_high, last_load, ts_cyc, done_cyc, rd_cyc;
    logic sck_prev = 1'b0, load_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (clr_req) begin
            n_rd = 0; n_underflow = 0; n_load_cyc = 0; n_load_rise = 0; n_ts = 0; n_done = 0;
            n_sck_in_load = 0; n_rxvld = 0; hi_run = 0; hi_bad = 0; low_run = 0; max_low = 0;
            first_rise = -1; last_high = 0; last_load = 0; ts_cyc = 0; done_cyc = 0; rd_cyc = 0;
            bits_q.delete();
        end else begin
            if (fifo_rd) begin n_rd++; rd_cyc = cyc; if (fifo_empty) n_underflow++; end
            if (spi_sck && !sck_prev) begin
                bits_q.push_back(spi_mosi);
                if (first_rise < 0) first_rise = cyc;
            end
            if (spi_sck) begin hi_run++; last_high = cyc; end
            else if (sck_prev) begin if (hi_run != int'(div) + 1) hi_bad++; hi_run = 0; end
            if (busy && !spi_sck && !spi_load) low_run++; else low_run = 0;
            if (low_run > max_low) max_low = low_run;
            if (spi_load) begin
                n_load_cyc++; last_load = cyc;
                if (spi_sck) n_sck_in_load++;
                if (!load_prev) n_load_rise++;
            end
            if (timer_start) begin n_ts++; ts_cyc = cyc; end
            if (work_done) begin n_done++; done_cyc = cyc; end
            if (rx_vld) n_rxvld++;
        end
        spi_miso = (bits_q.size() < 32) ? miso_pat[31 - bits_q.size()] : 1'b0;
        sck_prev = spi_sck;
        load_prev = spi_load;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_stats();
        clr_req = 1'b1; step(); clr_req = 1'b0;
    endtask

    task automatic write_word(input logic [31:0] d);
        push_v = 1'b1; push_d = d; step(); push_v = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && n_done < n; i++) step();
        ok = (n_done >= n);
    endtask

    function automatic logic [31:0] got_word(input int k);
        logic [31:0] w = 32'h0;
        for (int i = 0; i < 32; i++)
            if (32 * k + i < bits_q.size()) w = {w[30:0], bits_q[32 * k + i]};
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1; reg_rst = 1'b0; reg_run = 1'b0; wn = 8'd1; div = 8'd0;
        repeat (3) step();
        rst = 1'b0; step();
        total_cnt++;
        if ({fifo_rd, spi_sck, spi_mosi, spi_load, timer_start, busy, work_done} !== 7'b0)
            $display("FAIL reset_outputs: got %b want 0000000",
                     {fifo_rd, spi_sck, spi_mosi, spi_load, timer_start, busy, work_done});
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state);
        else pass_cnt++;
    endtask

    task automatic test_single();
        bit ok;
        div = 8'd0; wn = 8'd1; tdur = 4;
        write_word(32'hA5A5_0001);
        clear_stats();
        reg_run = 1'b1;
        wait_done(1, 400, ok);
        reg_run = 1'b0;
        total_cnt++;
        if (!ok) $display("FAIL single_done: work_done count %0d want 1", n_done); else pass_cnt++;
        total_cnt++;
        if (bits_q.size() != 32) $display("FAIL single_pulses: got %0d want 32", bits_q.size());
        else pass_cnt++;
        total_cnt++;
        if (got_word(0) !== 32'hA5A5_0001)
            $display("FAIL single_mosi: got %h want a5a50001", got_word(0));
        else pass_cnt++;
        total_cnt++;
        if (hi_bad != 0) $display("FAIL single_sck_high: %0d bad phases want 0", hi_bad); else pass_cnt++;
        total_cnt++;
        if (n_load_cyc != 1 || n_sck_in_load != 0)
            $display("FAIL single_load: %0d cycles (%0d with sck) want 1 (0)", n_load_cyc, n_sck_in_load);
        else pass_cnt++;
        total_cnt++;
        if (n_ts != 1 || ts_cyc - last_load != 1)
            $display("FAIL single_timer_start: %0d pulses at +%0d want 1 at +1", n_ts, ts_cyc - last_load);
        else pass_cnt++;
        total_cnt++;
        if (done_cyc - ts_cyc != tdur + 2)
            $display("FAIL single_done_time: got %0d want %0d", done_cyc - ts_cyc, tdur + 2);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [31:0] exp_q[$];
        bit ok;
        int wcyc;
        div = 8'd0; wn = 8'd3; tdur = 3;
        for (int i = 0; i < 3; i++) exp_q.push_back($urandom());
        write_word(exp_q[0]); write_word(exp_q[1]);
        clear_stats();
        reg_run = 1'b1;
        for (int i = 0; i < 400 && n_rd < 2; i++) step();
        repeat (64 + 100) step();
        wcyc = cyc + 1;
        write_word(exp_q[2]);
        wait_done(1, 600, ok);
        reg_run = 1'b0;
        total_cnt++;
        if (!ok) $display("FAIL stall_done: work_done count %0d want 1", n_done); else pass_cnt++;
        total_cnt++;
        if (max_low < 90) $display("FAIL stall_sck_low: longest low %0d want >= 90", max_low); else pass_cnt++;
        total_cnt++;
        if (rd_cyc - wcyc != 1) $display("FAIL stall_resume: pop at +%0d want +1", rd_cyc - wcyc);
        else pass_cnt++;
        total_cnt++;
        if (n_rd != 3 || n_underflow != 0)
            $display("FAIL stall_pops: %0d pops (%0d empty) want 3 (0)", n_rd, n_underflow);
        else pass_cnt++;
        total_cnt++;
        if (n_load_rise != 1) $display("FAIL stall_loads: got %0d want 1", n_load_rise); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (got_word(k) !== exp_q[k]) $display("FAIL stall_word%0d: got %h want %h", k, got_word(k), exp_q[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_busy_hold();
        bit ok;
        int dcyc;
        logic [31:0] w;
        div = 8'd1; wn = 8'd1; tdur = 2;
        w = $urandom();
        ext_busy = 1'b1;
        write_word(w);
        clear_stats();
        reg_run = 1'b1;
        repeat (50) step();
        total_cnt++;
        if (n_rd != 0) $display("FAIL hold_no_pop: got %0d pops want 0", n_rd); else pass_cnt++;
        dcyc = cyc + 1;
        ext_busy = 1'b0;
        wait_done(1, 400, ok);
        reg_run = 1'b0;
        total_cnt++;
        if (!ok || rd_cyc != dcyc) $display("FAIL hold_start: done %0d pop at +%0d want 1 at +0", n_done, rd_cyc - dcyc);
        else pass_cnt++;
        total_cnt++;
        if (got_word(0) !== w) $display("FAIL hold_word: got %h want %h", got_word(0), w); else pass_cnt++;
    endtask

    task automatic test_abort();
        div = 8'd3; wn = 8'd1;
        write_word(32'h1234_5678);
        clear_stats();
        reg_run = 1'b1;
        for (int i = 0; i < 800 && bits_q.size() < 20; i++) step();
        reg_rst = 1'b1; reg_run = 1'b0;
        step();
        reg_rst = 1'b0;
        total_cnt++;
        if ({spi_sck, spi_mosi, busy, spi_load} !== 4'b0)
            $display("FAIL abort_outputs: got %b want 0000", {spi_sck, spi_mosi, busy, spi_load});
        else pass_cnt++;
        repeat (300) step();
        total_cnt++;
        if (n_load_cyc != 0 || n_ts != 0)
            $display("FAIL abort_no_load: load %0d start %0d want 0 0", n_load_cyc, n_ts);
        else pass_cnt++;
    endtask

    task automatic test_zero_words();
        bit ok;
        logic [31:0] w;
        div = 8'd2; wn = 8'd0; tdur = 5;
        w = $urandom();
        write_word(w);
        clear_stats();
        reg_run = 1'b1;
        wait_done(1, 600, ok);
        reg_run = 1'b0;
        total_cnt++;
        if (!ok || n_rd != 1) $display("FAIL zero_words: done %0d pops %0d want 1 1", n_done, n_rd); else pass_cnt++;
        total_cnt++;
        if (last_high - first_rise + 1 != 189)
            $display("FAIL zero_span: got %0d want 189", last_high - first_rise + 1);
        else pass_cnt++;
        total_cnt++;
        if (hi_bad != 0 || n_load_cyc != 3)
            $display("FAIL zero_phases: bad %0d load %0d want 0 3", hi_bad, n_load_cyc);
        else pass_cnt++;
        total_cnt++;
        if (got_word(0) !== w) $display("FAIL zero_word: got %h want %h", got_word(0), w); else pass_cnt++;
    endtask

    task automatic test_random();
        for (int t = 0; t < 6; t++) begin
            logic [31:0] exp_q[$];
            bit ok;
            int nw, bad;
            div = 8'($urandom_range(0, 3)); wn = 8'($urandom_range(0, 3)); tdur = $urandom_range(1, 20);
            nw = (wn == 0) ? 1 : int'(wn);
            for (int i = 0; i < nw; i++) exp_q.push_back($urandom());
            clear_stats();
            write_word(exp_q[0]);
            reg_run = 1'b1;
            for (int i = 1; i < nw; i++) begin
                repeat ($urandom_range(0, 80)) step();
                write_word(exp_q[i]);
            end
            wait_done(1, 3000, ok);
            reg_run = 1'b0;
            bad = 0;
            for (int k = 0; k < nw; k++) if (got_word(k) !== exp_q[k]) bad++;
            total_cnt++;
            if (!ok || bad != 0 || bits_q.size() != 32 * nw)
                $display("FAIL rand%0d_words: done %0d bad %0d bits %0d want 1 0 %0d", t, n_done, bad, bits_q.size(), 32 * nw);
            else pass_cnt++;
            total_cnt++;
            if (n_rd != nw || n_load_rise != 1 || n_load_cyc != int'(div) + 1)
                $display("FAIL rand%0d_ctrl: pops %0d loads %0d/%0d want %0d 1/%0d", t, n_rd, n_load_rise, n_load_cyc, nw, int'(div) + 1);
            else pass_cnt++;
            total_cnt++;
            if (done_cyc - ts_cyc != tdur + 2 || hi_bad != 0)
                $display("FAIL rand%0d_timing: wait %0d bad %0d want %0d 0", t, done_cyc - ts_cyc, hi_bad, tdur + 2);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int d1;
        div = 8'd0; wn = 8'd1; tdur = 2;
        write_word($urandom()); write_word($urandom());
        clear_stats();
        reg_run = 1'b1;
        wait_done(1, 400, ok);
        d1 = done_cyc;
        wait_done(2, 400, ok);
        reg_run = 1'b0;
        total_cnt++;
        if (!ok || n_rd != 2) $display("FAIL b2b_count: done %0d pops %0d want 2 2", n_done, n_rd); else pass_cnt++;
        total_cnt++;
        if (n_ts != 2 || ts_cyc - d1 > 150 || ts_cyc - d1 < 64)
            $display("FAIL b2b_restart: second start %0d after done want 64..150", ts_cyc - d1);
        else pass_cnt++;
    endtask

`ifdef API_MISO_EN
    task automatic test_miso();
        bit ok;
        div = 8'd1; wn = 8'd1; tdur = 2;
        miso_pat = 32'hDEAD_BEEF;
        write_word($urandom());
        clear_stats();
        reg_run = 1'b1;
        wait_done(1, 600, ok);
        reg_run = 1'b0;
        total_cnt++;
        if (!ok || rx_data !== 32'hDEAD_BEEF) $display("FAIL miso_data: got %h want deadbeef", rx_data); else pass_cnt++;
        total_cnt++;
        if (n_rxvld != 1) $display("FAIL miso_vld: got %0d pulses want 1", n_rxvld); else pass_cnt++;
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_busy_hold();
        test_abort();
        test_zero_words();
        test_random();
        test_back_to_back();
`ifdef API_MISO_EN
        test_miso();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
